// File: rtl/mic_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mic_capture_ctrl
//  Description : Triggered capture scheduler for the 24-bit microphone sample
//                stream. Powers the receiver up and down through its reset,
//                skips warm-up samples, arms on an amplitude threshold, stores
//                a decimated burst and drains it over a valid/ready port.
//  Revision    : 1.0  initial release
// ============================================================================
module mic_capture_ctrl #(
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH),
  parameter int WARMUP = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [23:0]   threshold,
  input  logic [AW:0]   num_samples,
  input  logic [3:0]    decim,
  input  logic [23:0]   mic_value,
  input  logic          mic_we,
  output logic          mic_rst,
  output logic [23:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic [1:0]    state_o
);

  // Warm-up counter must hold the value WARMUP itself; keep at least one bit.
  localparam int             c_ww     = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
  localparam logic [c_ww-1:0] c_warmup = c_ww'(WARMUP);
  localparam logic [c_ww-1:0] c_w_one  = c_ww'(1);
  localparam logic [AW:0]    c_depth  = (AW + 1)'(DEPTH);
  localparam logic [AW:0]    c_one    = (AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [23:0]      thr_q, thr_d;
  logic [AW:0]      n_q, n_d;
  logic [3:0]       decim_q, decim_d;
  logic [c_ww-1:0]  warm_q, warm_d;
  logic [3:0]       dec_q, dec_d;
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic [23:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;

  logic [23:0]      mem_q [DEPTH];
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [23:0]      mem_wdata;

  logic [23:0]      abs_val;
  logic [AW:0]      n_eff;
  logic             handshake;

  // Magnitude of the incoming sample; the most negative code saturates.
  always_comb begin
    abs_val = mic_value;
    if (mic_value == 24'h800000) begin
      abs_val = 24'h7FFFFF;
    end else if (mic_value[23]) begin
      abs_val = 24'(~mic_value + 24'd1);
    end
  end

  // A zero or oversized request captures the whole buffer.
  always_comb begin
    n_eff = num_samples;
    if (num_samples == '0 || num_samples > c_depth) begin
      n_eff = c_depth;
    end
  end

  assign handshake = out_valid_q & out_ready;

  // Next-state, counter, buffer-write and readout logic.
  always_comb begin
    state_d     = state_q;
    thr_d       = thr_q;
    n_d         = n_q;
    decim_d     = decim_q;
    warm_d      = warm_q;
    dec_d       = dec_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mem_we      = 1'b0;
    mem_addr    = wr_q[AW-1:0];
    mem_wdata   = mic_value;

    if (abort) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            thr_d   = threshold;
            n_d     = n_eff;
            decim_d = decim;
            warm_d  = '0;
            dec_d   = '0;
            wr_d    = '0;
            rd_d    = '0;
            state_d = S_ARMED;
          end
        end

        S_ARMED: begin
          if (mic_we) begin
            if (warm_q < c_warmup) begin
              warm_d = warm_q + c_w_one;
            end else if (abs_val >= thr_q) begin
              // Trigger sample is the first stored sample.
              mem_we   = 1'b1;
              mem_addr = '0;
              wr_d     = c_one;
              dec_d    = '0;
              state_d  = S_CAPTURE;
            end
          end
        end

        S_CAPTURE: begin
          if (wr_q >= n_q) begin
            state_d = S_DONE;
          end else if (mic_we) begin
            if (dec_q == decim_q) begin
              mem_we = 1'b1;
              wr_d   = wr_q + c_one;
              dec_d  = '0;
            end else begin
              dec_d  = dec_q + 4'd1;
            end
          end
        end

        S_DONE: begin
          // rd_q counts samples fetched into the output register; once all
          // are fetched, the handshake on the last one ends the burst.
          if (handshake && rd_q == n_q) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else if ((!out_valid_q || handshake) && rd_q < n_q) begin
            out_data_d  = mem_q[rd_q[AW-1:0]];
            out_valid_d = 1'b1;
            rd_d        = rd_q + c_one;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Control and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      thr_q       <= '0;
      n_q         <= '0;
      decim_q     <= '0;
      warm_q      <= '0;
      dec_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      thr_q       <= thr_d;
      n_q         <= n_d;
      decim_q     <= decim_d;
      warm_q      <= warm_d;
      dec_q       <= dec_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Capture buffer; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_addr] <= mem_wdata;
    end
  end

  // Receiver runs only while waiting for a trigger or capturing.
  assign mic_rst   = (state_q != S_ARMED) && (state_q != S_CAPTURE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != S_IDLE);
  assign state_o   = state_q;

endmodule
`default_nettype wire

// File: doc/mic_capture_ctrl.md
Name: mic_capture_ctrl

Overview:
- Triggered capture scheduler for the 24-bit microphone sample stream (sample word + one-cycle write strobe) produced by the INMP441 receiver.
- Powers the receiver up and down through its reset, discards warm-up samples and arms on an amplitude threshold.
- Records a decimated burst into an internal buffer, then drains the buffer to a consumer over a valid/ready port.
- Sits between the mic receiver and display/analysis logic (scope, VU, spectrum).

Parameters:
DEPTH, 256, capture buffer depth in samples (power of two).
AW, $clog2(DEPTH), buffer address width.
WARMUP, 4, mic strobes discarded after leaving receiver reset.

Ports:
clk  in  1  system clock
reset  in  1  reset
start  in  1  one-cycle arm request; honoured only in IDLE
abort  in  1  return to IDLE from any state
threshold  in  24  unsigned trigger level on |sample|
num_samples  in  AW+1  samples to capture; 0 or >DEPTH treated as DEPTH
decim  in  4  store every (decim+1)-th strobe
mic_value  in  24  signed two's-complement sample from receiver
mic_we  in  1  one-cycle sample strobe
mic_rst  out  1  active-high reset to the receiver
out_data  out  24  captured sample
out_valid  out  1  out_data valid
out_ready  in  1  consumer accept
busy  out  1  state != IDLE
state_o  out  2  0=IDLE 1=ARMED 2=CAPTURE 3=DONE

Behaviour:
- Clock clk; reset is asynchronous, active-high.
- Reset values: state IDLE, mic_rst=1, out_valid=0, out_data=0, busy=0, all counters 0.
- Configuration: threshold, num_samples and decim are latched on the accepted start; later changes have no effect until the next capture.
- IDLE: mic_rst=1.
  - On start: latch config, clear warm-up, decimation and write counters, go to ARMED next cycle.
- ARMED: mic_rst=0.
  - The first WARMUP mic_we strobes are ignored.
  - Each later strobe computes |mic_value|; the absolute value of 24'h800000 saturates to 24'h7FFFFF.
  - If |mic_value| >= threshold: write that sample to addr 0, set wr_cnt=1 and dec_cnt=0, go to CAPTURE.
  - threshold=0 triggers on the first post-warm-up strobe.
- CAPTURE: mic_rst=0.
  - On each mic_we: if dec_cnt==decim, write the sample at wr_cnt, increment wr_cnt and clear dec_cnt; otherwise increment dec_cnt.
  - The trigger sample counts as stored. Stored samples are therefore strobes T, T+(decim+1), T+2(decim+1), ... where T is the trigger strobe.
  - When wr_cnt reaches the effective count N: go to DONE on the following cycle, with mic_rst=1 from that cycle on.
  - mic_we is ignored in all states other than ARMED and CAPTURE.
- DONE: samples are read out from addr 0 upward.
  - Buffer read latency is 1 cycle. out_valid rises at most 2 cycles after entering DONE.
  - out_data/out_valid are held stable while out_valid=1 and out_ready=0.
  - Each handshake (out_valid & out_ready) advances the read pointer. Back-to-back handshakes sustain 1 sample/cycle, using prefetch or a skid register.
  - After the N-th handshake: out_valid=0 next cycle, state IDLE.
  - Exactly N samples are delivered, never more.
- abort:
  - Takes priority over every other event in the same cycle. The next state is IDLE with out_valid=0 and mic_rst=1.
  - Buffer contents are undefined afterwards.
  - abort and start in the same cycle: abort wins and start is dropped.
- start outside IDLE: ignored, with no effect on counters.
- Writes use the address from wr_cnt[AW-1:0]; with N=DEPTH the last write lands at DEPTH-1 and no address wrap is visible.
- Reset mid-operation returns immediately to the reset values. Buffer RAM contents need not be cleared.

Test Plan:
- DEPTH=16, WARMUP=4, threshold=100, num_samples=4, decim=0. Strobes 500,500,500,500 (warm-up), then 10, 99, -100, 7, 8, 9 -> trigger on -100; out delivers 0xFFFF9C, 7, 8, 9; back to IDLE; mic_rst high again.
- decim=2, num_samples=3, threshold=0. Post-warm-up strobes 1..9 -> out 1, 4, 7.
- num_samples=0, DEPTH=16, ramp 0..40 after warm-up -> exactly 16 samples out, 0..15.
- Readout with out_ready toggling 1,0,0,1,... -> out_data held during stalls; no sample lost or duplicated. Continuous out_ready -> one sample per cycle.
- abort asserted during CAPTURE after 2 writes, same cycle as mic_we -> IDLE next cycle, out_valid never rises. start pulsed during ARMED -> ignored.
- Sample 0x800000 with threshold=0x7FFFFF -> triggers (saturated abs). Async reset pulse in DONE -> out_valid=0, mic_rst=1 without a clock edge.
